// File: rtl/zero_run_monitor.sv
// zero_run_monitor
//
// Registered zero-word monitor for datapath taps. For each word accepted on
// in_valid it reports, one cycle later, whether the word was nonzero, the
// length of the current run of consecutive all-zero words, and a saturating
// total of zero words. A sticky alarm rises when the run reaches RUN_THRESH.
//
// Optional feature macro: ZERO_RUN_LZC_EN
//   When defined, adds the lead_zeros output (leading-zero count of the last
//   accepted word; WIDTH for an all-zero word).
//
// Parameters:
//   WIDTH      - data word width (>= 1)
//   CNT_W      - width of run_len / zero_count (>= 1)
//   RUN_THRESH - zero-run length that sets run_alarm (1 .. 2^CNT_W-1)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - data_in is valid this cycle
//   data_in    - word under test
//   clear      - synchronous clear of run_alarm, run_len, zero_count
//   out_valid  - outputs reflect a word accepted in the previous cycle
//   is_nonzero - OR-reduction of the last accepted word
//   run_len    - consecutive zero words, saturating
//   zero_count - total zero words since reset/clear, saturating
//   run_alarm  - sticky; set when run_len reaches RUN_THRESH
//   lead_zeros - leading zeros of last accepted word (ZERO_RUN_LZC_EN only)
module zero_run_monitor #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int RUN_THRESH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           clear,
    output logic                           out_valid,
    output logic                           is_nonzero,
    output logic [CNT_W-1:0]               run_len,
    output logic [CNT_W-1:0]               zero_count,
`ifdef ZERO_RUN_LZC_EN
    output logic [$clog2(WIDTH+1)-1:0]     lead_zeros,
`endif
    output logic                           run_alarm
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef ZERO_RUN_LZC_EN
    localparam int LZ_W = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit overwrite lower ones.
    function automatic logic [LZ_W-1:0] lzc(input logic [WIDTH-1:0] w);
        logic [LZ_W-1:0] n;
        n = LZ_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) n = LZ_W'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [LZ_W-1:0] lz_next;
`endif

    logic             word_zero;
    logic [CNT_W-1:0] run_base, tot_base;
    logic [CNT_W-1:0] run_next, tot_next;
    logic             alarm_next;
    logic             nz_next;

    assign word_zero = ~|data_in;

    always_comb begin
        // A clear restarts both counters before the current word is counted.
        run_base   = clear ? '0 : run_len;
        tot_base   = clear ? '0 : zero_count;
        run_next   = run_base;
        tot_next   = tot_base;
        nz_next    = is_nonzero;
        alarm_next = clear ? 1'b0 : run_alarm;
`ifdef ZERO_RUN_LZC_EN
        lz_next    = lead_zeros;
`endif
        if (in_valid) begin
            nz_next = ~word_zero;
`ifdef ZERO_RUN_LZC_EN
            lz_next = lzc(data_in);
`endif
            if (word_zero) begin
                run_next = sat_inc(run_base);
                tot_next = sat_inc(tot_base);
                // Clear wins over an alarm the restarted run would trigger.
                if (!clear && run_next == THRESH) alarm_next = 1'b1;
            end else begin
                run_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            is_nonzero <= 1'b0;
            run_len    <= '0;
            zero_count <= '0;
            run_alarm  <= 1'b0;
`ifdef ZERO_RUN_LZC_EN
            lead_zeros <= '0;
`endif
        end else begin
            out_valid  <= in_valid;
            is_nonzero <= nz_next;
            run_len    <= run_next;
            zero_count <= tot_next;
            run_alarm  <= alarm_next;
`ifdef ZERO_RUN_LZC_EN
            lead_zeros <= lz_next;
`endif
        end
    end

endmodule

// File: tb/tb_zero_run_monitor.sv
// Testbench for zero_run_monitor (WIDTH=8, CNT_W=8, RUN_THRESH=4).
// Directed scenarios followed by a randomized stream, all checked against a
// behavioural model of run length / zero total / alarm kept as plain integers.
module tb_zero_run_monitor;
    localparam int W    = 8;
    localparam int CW   = 8;
    localparam int TH   = 4;
    localparam int LZW  = $clog2(W + 1);
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, clear;
    logic [W-1:0]  data_in;
    logic          out_valid, is_nonzero, run_alarm;
    logic [CW-1:0] run_len, zero_count;
`ifdef ZERO_RUN_LZC_EN
    logic [LZW-1:0] lead_zeros;
`endif

    always #5 clk = ~clk;

    zero_run_monitor #(.WIDTH(W), .CNT_W(CW), .RUN_THRESH(TH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .clear      (clear),
        .out_valid  (out_valid),
        .is_nonzero (is_nonzero),
        .run_len    (run_len),
        .zero_count (zero_count),
`ifdef ZERO_RUN_LZC_EN
        .lead_zeros (lead_zeros),
`endif
        .run_alarm  (run_alarm)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_run, m_tot, m_lz;
    bit m_ov, m_nz, m_alarm;

    function automatic void model_reset();
        m_run = 0; m_tot = 0; m_lz = 0;
        m_ov = 0; m_nz = 0; m_alarm = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] d, input bit c);
        m_ov = v;
        if (c) begin
            m_run = 0; m_tot = 0; m_alarm = 0;
        end
        if (v) begin
            m_nz = (d != 0);
            m_lz = W;
            for (int i = W - 1; i >= 0; i--) begin
                if (d[i]) begin
                    m_lz = W - 1 - i;
                    break;
                end
            end
            if (d == 0) begin
                m_run = (m_run < MAXC) ? m_run + 1 : MAXC;
                m_tot = (m_tot < MAXC) ? m_tot + 1 : MAXC;
                if (!c && m_run == TH) m_alarm = 1;
            end else begin
                m_run = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"},  32'(out_valid),  32'(m_ov));
        chk({tag, ".is_nonzero"}, 32'(is_nonzero), 32'(m_nz));
        chk({tag, ".run_len"},    32'(run_len),    32'(m_run));
        chk({tag, ".zero_count"}, 32'(zero_count), 32'(m_tot));
        chk({tag, ".run_alarm"},  32'(run_alarm),  32'(m_alarm));
`ifdef ZERO_RUN_LZC_EN
        chk({tag, ".lead_zeros"}, 32'(lead_zeros), 32'(m_lz));
`endif
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit c, input string tag);
        in_valid = v;
        data_in  = d;
        clear    = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        check_all(tag);
    endtask

    logic [W-1:0] basic_words [5] = '{8'h00, 8'h01, 8'hAA, 8'h10, 8'hFF};
    int           basic_run   [5] = '{1, 0, 0, 0, 0};
    int           basic_nz    [5] = '{0, 1, 1, 1, 1};
`ifdef ZERO_RUN_LZC_EN
    logic [W-1:0] lz_words [4] = '{8'h10, 8'h00, 8'h80, 8'h01};
    int           lz_exp   [4] = '{3, 8, 0, 7};
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; data_in = '0;
        model_reset();

        // Reset held with random inputs
        repeat (3) begin
            in_valid = 1'($urandom);
            clear    = 1'($urandom);
            data_in  = W'($urandom);
            @(posedge clk);
            #1;
            check_all("reset");
        end
        rst_n = 1'b1;
        step(0, 8'h00, 0, "idle");
        step(0, 8'h00, 0, "idle");

        // Basic stream
        for (int i = 0; i < 5; i++) begin
            step(1, basic_words[i], 0, "basic");
            chk("basic.run_const", 32'(run_len), 32'(basic_run[i]));
            chk("basic.nz_const",  32'(is_nonzero), 32'(basic_nz[i]));
            chk("basic.tot_const", 32'(zero_count), 32'd1);
        end

        // Alarm, back-to-back
        for (int i = 1; i <= 4; i++) begin
            step(1, 8'h00, 0, "alarm");
            chk("alarm.run_const", 32'(run_len), 32'(i));
            chk("alarm.flag_const", 32'(run_alarm), 32'(i == 4));
        end
        step(1, 8'h01, 0, "alarm_nz");
        chk("alarm_sticky", 32'(run_alarm), 32'd1);

        // Clear alone, then alarm again with gaps
        step(0, 8'h00, 1, "clear_only");
        chk("clear_only.alarm", 32'(run_alarm), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 8'h00, 0, "gap_word");
            chk("gap.run_const", 32'(run_len), 32'(i));
            step(0, 8'h00, 0, "gap_idle");
            chk("gap.ov_const", 32'(out_valid), 32'd0);
        end
        chk("gap.alarm_const", 32'(run_alarm), 32'd1);
        step(1, 8'h01, 0, "gap_nz");

        // Clear collision
        step(1, 8'h00, 1, "collide");
        chk("collide.alarm", 32'(run_alarm), 32'd0);
        chk("collide.run",   32'(run_len),   32'd1);
        chk("collide.tot",   32'(zero_count), 32'd1);
        step(0, 8'h00, 1, "clear2");
        chk("clear2.run", 32'(run_len),    32'd0);
        chk("clear2.tot", 32'(zero_count), 32'd0);

        // Saturation
        repeat (300) step(1, 8'h00, 0, "sat");
        chk("sat.run",   32'(run_len),    32'd255);
        chk("sat.tot",   32'(zero_count), 32'd255);
        chk("sat.alarm", 32'(run_alarm),  32'd1);

`ifdef ZERO_RUN_LZC_EN
        for (int i = 0; i < 4; i++) begin
            step(1, lz_words[i], 0, "lzc");
            chk("lzc.const", 32'(lead_zeros), 32'(lz_exp[i]));
        end
`endif

        // Asynchronous reset mid-stream
        step(0, 8'h00, 1, "pre_rst_clr");
        step(1, 8'h00, 0, "pre_rst");
        step(1, 8'h00, 0, "pre_rst");
        in_valid = 1'b1; data_in = 8'h00; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 8'h00, 0, "post_rst");
        chk("post_rst.run", 32'(run_len), 32'd1);

        // Randomized stream
        repeat (3000) begin
            bit           v, c;
            logic [W-1:0] d;
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 49) == 0);
            d = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            step(v, d, c, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zero_run_monitor.md
# zero_run_monitor

Parametrised, registered successor to the team's combinational zero detector. It takes a stream of WIDTH-bit words qualified by `in_valid` and produces three results one cycle later: a registered nonzero flag per word, the length of the current run of consecutive all-zero words, and a saturating total of zero words seen. A sticky alarm raises when the zero run reaches a programmable threshold. The block sits on datapath monitor taps, where stuck-at-zero buses must be flagged to status logic.

## Interface
- `WIDTH`, 8: data word width; must be ≥ 1.
- `CNT_W`, 8: width of the run and total counters; must be ≥ 1.
- `RUN_THRESH`, 4: zero-run length that sets the alarm; legal range 1 ≤ RUN_THRESH ≤ 2^CNT_W−1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `data_in` is valid this cycle.
- `data_in` input WIDTH: word under test.
- `clear` input 1: synchronous clear of `run_alarm`, `run_len` and `zero_count`.
- `out_valid` output 1: registered results correspond to a word accepted in the previous cycle.
- `is_nonzero` output 1: OR-reduction of the last accepted word.
- `run_len` output CNT_W: current count of consecutive zero words, saturating.
- `zero_count` output CNT_W: total zero words since reset or clear, saturating.
- `run_alarm` output 1: sticky flag; set when `run_len` reaches RUN_THRESH.
- `lead_zeros` output $clog2(WIDTH+1): leading-zero count of the last accepted word. Present only with `ZERO_RUN_LZC_EN`.

## Operation
- Accept: every cycle with `in_valid`=1. There is no backpressure.
- `is_nonzero` <= |`data_in`.
- Zero word: `run_len` <= sat(`run_len`+1); `zero_count` <= sat(`zero_count`+1).
- Nonzero word: `run_len` <= 0; `zero_count` holds.
- `run_alarm` is set when the next value of `run_len` equals RUN_THRESH. It then stays 1 until `clear` or reset, even after a nonzero word.
- Saturation: counters stop at 2^CNT_W−1 and never wrap. A saturated `run_len` keeps `run_alarm` at 1.
- `in_valid`=0: `out_valid` <= 0. `is_nonzero`, `run_len`, `zero_count`, `run_alarm` and `lead_zeros` all hold.
- `clear` without `in_valid`: `run_len`, `zero_count` and `run_alarm` <= 0.
- `clear` with `in_valid` in the same cycle:
  - Counters restart from 0, then count this word: `run_len` and `zero_count` <= 1 if the word is zero, else 0.
  - `run_alarm` <= 0, even if the restarted run would meet RUN_THRESH=1. Clear wins.
  - `is_nonzero` and `out_valid` update normally.

## Timing
- Latency: all outputs registered, 1 cycle from the accepting edge.
- Throughput: one word per cycle.
- Reset values: `out_valid`=0, `is_nonzero`=0, `run_len`=0, `zero_count`=0, `run_alarm`=0, `lead_zeros`=0.
- Reset asserted mid-stream: outputs clear immediately (asynchronously). The first word accepted after release starts a new run of length 1 or 0.
- No combinational path from any input to any output.

## Configuration
- `ZERO_RUN_LZC_EN` defined:
  - Adds the `lead_zeros` port, registered alongside `is_nonzero` and updated on accepted words only.
  - Value is the number of zeros above the most-significant 1; WIDTH for an all-zero word.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, CNT_W=8, RUN_THRESH=4.
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0; after release with `in_valid`=0, outputs stay 0.
- Basic stream: 00,01,AA,10,FF on consecutive cycles -> one cycle later `is_nonzero`=0,1,1,1,1; `run_len`=1,0,0,0,0; `zero_count`=1,1,1,1,1; `out_valid`=1 for five cycles.
- Alarm: 00×4 then 01 -> `run_len`=1,2,3,4,0; `run_alarm` rises with `run_len`=4 and stays 1 after the 01. Repeat with `in_valid` gaps between words -> same values; `out_valid`=0 in the gaps.
- Clear collision: with `run_alarm`=1, assert `clear` and `in_valid` with 00 -> `run_alarm`=0, `run_len`=1, `zero_count`=1. Then `clear` alone -> `run_len`=0, `zero_count`=0.
- Saturation: 300 consecutive 00 -> `run_len` and `zero_count` reach 255 and hold; `run_alarm`=1 throughout once set.
- LZC (`ZERO_RUN_LZC_EN` defined): words 10,00,80,01 -> `lead_zeros`=3,8,0,7. Build without the macro -> compiles, and scenarios 1-5 still pass.
